// File: rtl/mvm_pkg.sv
// Shared widths, operand types and helpers for the MVM result path.
package mvm_pkg;

  localparam int unsigned IDATAW_DEF = 16;
  localparam int unsigned ACCUMW_DEF = 32;

  typedef logic signed [IDATAW_DEF-1:0] partial_t;
  typedef logic signed [ACCUMW_DEF-1:0] accum_t;

  typedef enum logic {
    ROW_IDLE = 1'b0,
    ROW_OPEN = 1'b1
  } row_state_e;

  function automatic accum_t sext(input partial_t x);
    return accum_t'(x);
  endfunction

endpackage

// File: rtl/accum_out_if.sv
// Lane-side beat stream and sink-side result handshake of one accumulate lane.
interface accum_out_if
  import mvm_pkg::*;
#(
  parameter int unsigned IDATAW = IDATAW_DEF,
  parameter int unsigned ACCUMW = ACCUMW_DEF
);

  logic                     ivalid;
  logic signed [IDATAW-1:0] idata;
  logic                     accum_first;
  logic                     accum_last;
  logic                     ovalid;
  logic signed [ACCUMW-1:0] odata;
  logic                     oready;
  logic                     almost_full;
  logic                     row_active;
  logic                     overflow;

  modport master (
    output ivalid, idata, accum_first, accum_last, oready,
    input  ovalid, odata, almost_full, row_active, overflow
  );

  modport slave (
    input  ivalid, idata, accum_first, accum_last, oready,
    output ovalid, odata, almost_full, row_active, overflow
  );

endinterface

// File: rtl/accum_out_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata reads 0 while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  output logic                         full,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/accum_out.sv
// Row accumulator for one dot-product lane: sums framed partial products and
// queues each finished row sum for the downstream sink.
module accum_out
  import mvm_pkg::*;
#(
  parameter int unsigned IDATAW     = IDATAW_DEF,
  parameter int unsigned ACCUMW     = ACCUMW_DEF,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  accum_out_if.slave  bus
);

  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

  row_state_e               state_q, state_d;
  logic signed [ACCUMW-1:0] accum_q, accum_d;
  logic signed [ACCUMW-1:0] ext, sum_next;
  logic                     ovf_q, ovf_d;
  logic                     push, pop, full, empty;
  logic [ACCUMW-1:0]        fifo_rdata;
  logic [CNTW-1:0]          fifo_count;

  assign ext      = ACCUMW'(bus.idata);
  assign sum_next = bus.accum_first ? ext : accum_q + ext;

  assign pop  = ~empty & bus.oready;
  assign push = bus.ivalid & bus.accum_last & (~full | pop);

  // Row tracker, accumulator and sticky drop flag.
  always_comb begin
    state_d = state_q;
    accum_d = accum_q;
    ovf_d   = ovf_q;
    if (bus.ivalid) begin
      if (bus.accum_last) begin
        state_d = ROW_IDLE;
        accum_d = '0;
        if (!push) ovf_d = 1'b1;
      end else begin
        state_d = ROW_OPEN;
        accum_d = sum_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ROW_IDLE;
      accum_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      accum_q <= accum_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (ACCUMW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (sum_next),
    .full  (full),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (empty),
    .count (fifo_count)
  );

  assign bus.ovalid      = ~empty;
  assign bus.odata       = fifo_rdata;
  assign bus.almost_full = (fifo_count >= CNTW'(FIFO_DEPTH - 1));
  assign bus.row_active  = (state_q == ROW_OPEN);
  assign bus.overflow    = ovf_q;

endmodule
